snoop_dcache: RTL and testbench
===============================

SNOOP_DCACHE -- requirements
Module: snoop_dcache

Interface
REQ-001 Parameter CPUID, default 0, core index used on the coherence bus.
REQ-002 Parameter SETS, default 8, number of direct-mapped sets; 2 words per block.
REQ-003 CLK  input  1  clock, rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 dmemREN  input  1  datapath load request.
REQ-006 dmemWEN  input  1  datapath store request.
REQ-007 dmemaddr  input  32  word address; tag [31:6], index [5:3], block offset [2], [1:0]=00.
REQ-008 dmemstore  input  32  store data.
REQ-009 dmemload  output  32  load data.
REQ-010 dhit  output  1  request complete this cycle.
REQ-011 halt  input  1  flush all dirty blocks.
REQ-012 flushed  output  1  flush finished, held high.
REQ-013 dREN, dWEN  output  1 each  memory-controller read / write request.
REQ-014 daddr  output  32  memory-controller word address.
REQ-015 dstore  output  32  write / cache-to-cache data.
REQ-016 dload  input  32  fill data.
REQ-017 dwait  input  1  controller busy; low = word accepted or returned.
REQ-018 cctrans  output  1  coherence bus request.
REQ-019 ccwrite  output  1  request is BusRdX (store miss or S-to-M upgrade).
REQ-020 ccwait  input  1  this cache is being snooped.
REQ-021 ccinv  input  1  invalidate snooped block.
REQ-022 ccsnoopaddr  input  32  snooped word address.

Function
REQ-023 Each line SHALL hold MSI state (I, S, M), tag, two words.
REQ-024 Load hitting S or M, or store hitting M, SHALL assert dhit combinationally in IDLE; store updates word and stays M.
REQ-025 Store hitting S SHALL be a miss with ccwrite=1 (upgrade); line data retained, refetch permitted.
REQ-026 States SHALL be IDLE, WB1, WB2, FILL1, FILL2, SNOOP, SWB1, SWB2, FLUSH, FLUSH_WB1, FLUSH_WB2, DONE.
REQ-027 IDLE with ccwait=1 SHALL enter SNOOP, taking priority over any pending miss or halt.
REQ-028 IDLE miss with victim M SHALL go WB1; otherwise FILL1.
REQ-029 WB1/WB2 SHALL assert dWEN with victim address word 0/1 and victim data; advance on dwait=0; WB2 then FILL1, victim becomes I.
REQ-030 FILL1/FILL2 SHALL assert cctrans, dREN, ccwrite=dmemWEN, daddr = block word 0/1; latch dload on dwait=0; ccwait=1 in FILL1 before first dwait=0 SHALL divert to SNOOP and retry FILL1 after.
REQ-031 After FILL2 line SHALL be M if store else S, tag written; return IDLE; request hits next cycle.
REQ-032 SNOOP SHALL compare ccsnoopaddr tag/index: hit M -> SWB1; hit S with ccinv=1 -> set I, IDLE; else IDLE.
REQ-033 SWB1/SWB2 SHALL assert dWEN, daddr = snooped block words 0/1, dstore = data; advance on dwait=0; after SWB2 line becomes I if ccinv else S.
REQ-034 dhit SHALL be 0 outside IDLE; cctrans only in FILL1/FILL2.
REQ-035 halt in IDLE SHALL enter FLUSH: sequentially visit sets 0..SETS-1; M lines written via FLUSH_WB1/2 then set I; after last set, DONE.
REQ-036 DONE SHALL hold flushed=1, ignore datapath, still service snoops (returning to DONE).
REQ-037 Simultaneous dmemREN and dmemWEN SHALL be treated as store.

Reset
REQ-038 nRST low SHALL force state IDLE, all lines I, tags/data 0, flush index 0, all outputs 0, mid-transaction included.
REQ-039 No request SHALL be reissued after reset.

Structure
REQ-040 MSI enum, state enum, address field struct in cpu_types_pkg.
REQ-041 One sub-module natural: dcache_snoop_cmp (tag/index compare returning hit and state); flush counter inline.

Verification
REQ-042 Load 0x40 cold -> FILL1/FILL2 daddr 0x40,0x44, cctrans=1 ccwrite=0; line S; load then dhit, dmemload=mem[0x40].
REQ-043 Store 0xDEADBEEF to 0x40 on S line -> cctrans=1 ccwrite=1, line M, next load 0x40 returns 0xDEADBEEF.
REQ-044 M line at 0x40, ccwait=1 ccsnoopaddr=0x40 ccinv=1 -> dWEN daddr 0x40,0x44, dstore 0xDEADBEEF; line I; later load 0x40 misses.
REQ-045 M line 0x40, load 0x440 (same index) -> WB1/WB2 to 0x40/0x44 before FILL of 0x440/0x444.
REQ-046 Two M lines, halt=1 -> exactly four dWEN words, then flushed=1 held; nRST pulse mid-FILL2 -> IDLE, all I, dREN=0.

Source files
------------

// File: rtl/snoop_dcache_pkg.sv
// Shared types for the snooping data cache: MSI line state, controller state
// and the default word-address field layout.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  // Encodings kept identical to the legacy localparam values.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WB1       = 4'd1,
    WB2       = 4'd2,
    FILL1     = 4'd3,
    FILL2     = 4'd4,
    SNOOP     = 4'd5,
    SWB1      = 4'd6,
    SWB2      = 4'd7,
    FLUSH     = 4'd8,
    FLUSH_WB1 = 4'd9,
    FLUSH_WB2 = 4'd10,
    DONE      = 4'd11
  } dstate_t;

  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;

endpackage

// File: rtl/snoop_dcache_if.sv
// Datapath, memory-controller and coherence-bus signals of one data cache.
interface snoop_dcache_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        halt;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        cctrans;
  logic        ccwrite;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;

  modport master (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
           ccwait, ccinv, ccsnoopaddr,
    output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

  modport slave (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
           ccwait, ccinv, ccsnoopaddr,
    input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );
endinterface

// File: rtl/snoop_dcache_cmp.sv
// Tag/index lookup of a word address against the line arrays.
module dcache_snoop_cmp
  import cpu_types_pkg::*;
#(
  parameter  int unsigned SETS = 8,
  localparam int unsigned IW   = $clog2(SETS),
  localparam int unsigned TW   = 29 - IW
) (
  input  logic [31:0]   addr,
  input  logic [TW-1:0] tags   [SETS],
  input  msi_t          states [SETS],
  output logic          hit,
  output msi_t          state,
  output logic [IW-1:0] idx
);
  assign idx   = addr[3 +: IW];
  assign state = states[idx];
  assign hit   = (state != MSI_I) && (tags[idx] == addr[31 -: TW]);
endmodule

// File: rtl/snoop_dcache.sv
// Direct-mapped, two-word-block MSI data cache with write-back, snoop
// write-back and halt-time flush.
module snoop_dcache
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUID = 0,
  parameter int unsigned SETS  = 8
) (
  input logic CLK,
  input logic nRST,
  snoop_dcache_if.master bus
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 29 - IW;

  logic [TW-1:0] tags   [SETS];
  msi_t          states [SETS];
  logic [31:0]   data0  [SETS];
  logic [31:0]   data1  [SETS];

  dstate_t       state, ret_state;
  logic [31:0]   fill_buf;
  logic [IW-1:0] flush_idx, snoop_idx;
  logic          snoop_inv, flushed_q;

  logic          req_hit, snp_hit;
  msi_t          req_st, snp_st;
  logic [IW-1:0] req_idx, snp_idx;

  dcache_snoop_cmp #(.SETS(SETS)) u_req_cmp (
    .addr(bus.dmemaddr), .tags(tags), .states(states),
    .hit(req_hit), .state(req_st), .idx(req_idx)
  );

  dcache_snoop_cmp #(.SETS(SETS)) u_snp_cmp (
    .addr(bus.ccsnoopaddr), .tags(tags), .states(states),
    .hit(snp_hit), .state(snp_st), .idx(snp_idx)
  );

  logic          req_wr, req_any, hit_ok, idle_hit, last_set;
  logic [TW-1:0] req_tag;
  logic          req_off;

  // A simultaneous load and store request is handled as a store.
  assign req_wr   = bus.dmemWEN;
  assign req_any  = bus.dmemREN | bus.dmemWEN;
  assign req_tag  = bus.dmemaddr[31 -: TW];
  assign req_off  = bus.dmemaddr[2];
  assign hit_ok   = req_hit && ((req_st == MSI_M) || !req_wr);
  assign idle_hit = (state == IDLE) && req_any && hit_ok && !bus.ccwait && !bus.halt;
  assign last_set = (flush_idx == IW'(SETS - 1));

  always_comb begin
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.cctrans  = 1'b0;
    bus.ccwrite  = 1'b0;
    bus.flushed  = flushed_q;
    case (state)
      IDLE: begin
        bus.dhit     = idle_hit;
        bus.dmemload = idle_hit ? (req_off ? data1[req_idx] : data0[req_idx]) : '0;
      end
      WB1, WB2: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[req_idx], req_idx, state == WB2, 2'b00};
        bus.dstore = (state == WB2) ? data1[req_idx] : data0[req_idx];
      end
      FILL1, FILL2: begin
        bus.cctrans = 1'b1;
        bus.dREN    = 1'b1;
        bus.ccwrite = req_wr;
        bus.daddr   = {req_tag, req_idx, state == FILL2, 2'b00};
      end
      SWB1, SWB2: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[snoop_idx], snoop_idx, state == SWB2, 2'b00};
        bus.dstore = (state == SWB2) ? data1[snoop_idx] : data0[snoop_idx];
      end
      FLUSH_WB1, FLUSH_WB2: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[flush_idx], flush_idx, state == FLUSH_WB2, 2'b00};
        bus.dstore = (state == FLUSH_WB2) ? data1[flush_idx] : data0[flush_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ret_state <= IDLE;
      fill_buf  <= '0;
      flush_idx <= '0;
      snoop_idx <= '0;
      snoop_inv <= 1'b0;
      flushed_q <= 1'b0;
      for (int unsigned i = 0; i < SETS; i++) begin
        tags[i]   <= '0;
        states[i] <= MSI_I;
        data0[i]  <= '0;
        data1[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.ccwait) begin
            state     <= SNOOP;
            ret_state <= IDLE;
          end else if (bus.halt) begin
            state     <= FLUSH;
            flush_idx <= '0;
          end else if (req_any) begin
            if (hit_ok) begin
              if (req_wr) begin
                if (req_off) data1[req_idx] <= bus.dmemstore;
                else         data0[req_idx] <= bus.dmemstore;
              end
            end else if (req_st == MSI_M) begin
              state <= WB1;
            end else begin
              state <= FILL1;
            end
          end
        end
        WB1: if (!bus.dwait) state <= WB2;
        WB2: if (!bus.dwait) begin
          states[req_idx] <= MSI_I;
          state           <= FILL1;
        end
        // A snoop arriving before the first fill word is accepted pre-empts
        // the fill; the fill restarts from word 0 afterwards.
        FILL1: begin
          if (!bus.dwait) begin
            fill_buf <= bus.dload;
            state    <= FILL2;
          end else if (bus.ccwait) begin
            state     <= SNOOP;
            ret_state <= FILL1;
          end
        end
        FILL2: if (!bus.dwait) begin
          data0[req_idx]  <= fill_buf;
          data1[req_idx]  <= bus.dload;
          tags[req_idx]   <= req_tag;
          states[req_idx] <= req_wr ? MSI_M : MSI_S;
          state           <= IDLE;
        end
        SNOOP: begin
          snoop_idx <= snp_idx;
          snoop_inv <= bus.ccinv;
          if (snp_hit && (snp_st == MSI_M)) begin
            state <= SWB1;
          end else begin
            if (snp_hit && bus.ccinv) states[snp_idx] <= MSI_I;
            state <= ret_state;
          end
        end
        SWB1: if (!bus.dwait) state <= SWB2;
        SWB2: if (!bus.dwait) begin
          states[snoop_idx] <= snoop_inv ? MSI_I : MSI_S;
          state             <= ret_state;
        end
        FLUSH: begin
          if (states[flush_idx] == MSI_M) begin
            state <= FLUSH_WB1;
          end else if (last_set) begin
            state     <= DONE;
            flushed_q <= 1'b1;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        FLUSH_WB1: if (!bus.dwait) state <= FLUSH_WB2;
        FLUSH_WB2: if (!bus.dwait) begin
          states[flush_idx] <= MSI_I;
          if (last_set) begin
            state     <= DONE;
            flushed_q <= 1'b1;
          end else begin
            flush_idx <= flush_idx + 1'b1;
            state     <= FLUSH;
          end
        end
        DONE: if (bus.ccwait) begin
          state     <= SNOOP;
          ret_state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_dcache.sv
// Directed bench for snoop_dcache with a single-cycle memory model and a
// log of every word the controller accepts or returns.
module tb_snoop_dcache;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic stall = 1'b0;
  always #5 CLK = ~CLK;

  snoop_dcache_if bus ();

  snoop_dcache #(.CPUID(0), .SETS(8)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  assign bus.dload = memrd(bus.daddr);
  assign bus.dwait = stall | !(bus.dREN | bus.dWEN);

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic        cc;
    logic        ccw;
  } ev_t;
  ev_t log_q[$];

  always @(posedge CLK) begin
    if (nRST && !bus.dwait) begin
      if (bus.dWEN) begin
        mem[bus.daddr] = bus.dstore;
        log_q.push_back('{w: 1'b1, a: bus.daddr, d: bus.dstore, cc: 1'b0, ccw: 1'b0});
      end else if (bus.dREN) begin
        log_q.push_back('{w: 1'b0, a: bus.daddr, d: bus.dload, cc: bus.cctrans, ccw: bus.ccwrite});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ev_t ev(input int i);
    ev_t e;
    e = '{w: 1'b0, a: '1, d: '1, cc: 1'bx, ccw: 1'bx};
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc, output bit ok);
    @(negedge CLK);
    log_q.delete();
    bus.dmemREN   = !wr;
    bus.dmemWEN   = wr;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    ok  = 1'b0;
    cyc = 0;
    rd  = '0;
    while (!ok && cyc < 60) begin
      #1;
      if (bus.dhit) begin
        ok = 1'b1;
        rd = bus.dmemload;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  logic [31:0] rd;
  int          cyc;
  bit          ok;
  int          n;

  initial begin
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0; bus.dmemstore = '0;
    bus.halt = 1'b0; bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;

    // Reset state
    @(negedge CLK);
    chk("rst_dREN", bus.dREN, 0);
    chk("rst_dWEN", bus.dWEN, 0);
    chk("rst_cctrans", bus.cctrans, 0);
    chk("rst_dhit", bus.dhit, 0);
    chk("rst_flushed", bus.flushed, 0);
    chk("rst_daddr", bus.daddr, 0);
    nRST = 1'b1;

    // Cold load 0x40: shared fill of both words
    access(0, 32'h40, 0, rd, cyc, ok);
    chk("ld40_ok", ok, 1);
    chk("ld40_cyc", cyc, 3);
    chk("ld40_data", rd, pat(32'h40));
    chk("ld40_nlog", log_q.size(), 2);
    chk("ld40_a0", ev(0).a, 32'h40);
    chk("ld40_cc", ev(0).cc, 1);
    chk("ld40_ccw", ev(0).ccw, 0);
    chk("ld40_a1", ev(1).a, 32'h44);

    // Second word of the S line hits
    access(0, 32'h44, 0, rd, cyc, ok);
    chk("ld44_cyc", cyc, 0);
    chk("ld44_data", rd, pat(32'h44));
    chk("ld44_nlog", log_q.size(), 0);

    // Store to S line is an upgrade miss
    access(1, 32'h40, 32'hDEADBEEF, rd, cyc, ok);
    chk("st40_cyc", cyc, 3);
    chk("st40_nlog", log_q.size(), 2);
    chk("st40_a0", ev(0).a, 32'h40);
    chk("st40_ccw", ev(0).ccw, 1);
    access(0, 32'h40, 0, rd, cyc, ok);
    chk("ld40m_cyc", cyc, 0);
    chk("ld40m_data", rd, 32'hDEADBEEF);

    // Snoop with invalidate on the M line
    @(negedge CLK);
    log_q.delete();
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h40; bus.ccinv = 1'b1;
    @(negedge CLK);
    chk("snp_dhit", bus.dhit, 0);
    @(negedge CLK);
    chk("swb1_dWEN", bus.dWEN, 1);
    chk("swb1_daddr", bus.daddr, 32'h40);
    chk("swb1_dstore", bus.dstore, 32'hDEADBEEF);
    bus.ccwait = 1'b0; bus.ccinv = 1'b0;
    repeat (3) @(negedge CLK);
    chk("snp_nlog", log_q.size(), 2);
    chk("snp_w1a", ev(1).a, 32'h44);
    chk("snp_w1d", ev(1).d, pat(32'h44));
    access(0, 32'h40, 0, rd, cyc, ok);
    chk("ld40i_cyc", cyc, 3);
    chk("ld40i_data", rd, 32'hDEADBEEF);

    // Conflict miss with an M victim writes back before filling
    access(1, 32'h40, 32'h12345678, rd, cyc, ok);
    chk("st40b_ccw", ev(0).ccw, 1);
    access(0, 32'h440, 0, rd, cyc, ok);
    chk("ld440_cyc", cyc, 5);
    chk("ld440_data", rd, pat(32'h440));
    chk("ld440_nlog", log_q.size(), 4);
    chk("ld440_e0w", ev(0).w, 1);
    chk("ld440_e0a", ev(0).a, 32'h40);
    chk("ld440_e0d", ev(0).d, 32'h12345678);
    chk("ld440_e1a", ev(1).a, 32'h44);
    chk("ld440_e1d", ev(1).d, pat(32'h44));
    chk("ld440_e2w", ev(2).w, 0);
    chk("ld440_e2a", ev(2).a, 32'h440);
    chk("ld440_e3a", ev(3).a, 32'h444);

    // Two M lines, then flush
    access(1, 32'h440, 32'hCAFEF00D, rd, cyc, ok);
    chk("st440_cyc", cyc, 3);
    access(1, 32'h88, 32'h0BADC0DE, rd, cyc, ok);
    chk("st88_cyc", cyc, 3);
    chk("st88_ccw", ev(0).ccw, 1);
    @(negedge CLK);
    log_q.delete();
    bus.halt = 1'b1;
    n = 0;
    while (!bus.flushed && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("fl_flushed", bus.flushed, 1);
    chk("fl_nlog", log_q.size(), 4);
    chk("fl_e0a", ev(0).a, 32'h440);
    chk("fl_e0d", ev(0).d, 32'hCAFEF00D);
    chk("fl_e1a", ev(1).a, 32'h444);
    chk("fl_e1d", ev(1).d, pat(32'h444));
    chk("fl_e2a", ev(2).a, 32'h88);
    chk("fl_e2d", ev(2).d, 32'h0BADC0DE);
    chk("fl_e3a", ev(3).a, 32'h8C);
    chk("fl_e3w", ev(3).w, 1);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h40;
    repeat (3) @(negedge CLK);
    chk("done_dhit", bus.dhit, 0);
    chk("done_flushed", bus.flushed, 1);
    chk("done_nlog", log_q.size(), 4);
    bus.dmemREN = 1'b0;

    // Reset pulse in the middle of FILL2
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; bus.halt = 1'b0;
    chk("rst2_flushed", bus.flushed, 0);
    @(negedge CLK);
    log_q.delete();
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
    @(negedge CLK);
    @(negedge CLK);
    stall = 1'b1;
    @(negedge CLK);
    chk("f2_dREN", bus.dREN, 1);
    nRST = 1'b0;
    #1;
    chk("rstf_dREN", bus.dREN, 0);
    chk("rstf_cctrans", bus.cctrans, 0);
    chk("rstf_daddr", bus.daddr, 0);
    bus.dmemREN = 1'b0;
    stall = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rstf_nlog", log_q.size(), 1);
    access(0, 32'h440, 0, rd, cyc, ok);
    chk("rstf_ld_cyc", cyc, 3);
    chk("rstf_ld_data", rd, 32'hCAFEF00D);
    chk("rstf_ld_e0w", ev(0).w, 0);
    chk("rstf_ld_nlog", log_q.size(), 2);

    // Snoop diverts a stalled FILL1, which is retried afterwards
    @(negedge CLK);
    log_q.delete();
    stall = 1'b1;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h200;
    @(negedge CLK);
    chk("dv_fill1_cc", bus.cctrans, 1);
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h88; bus.ccinv = 1'b1;
    @(negedge CLK);
    chk("dv_snoop_cc", bus.cctrans, 0);
    chk("dv_snoop_dhit", bus.dhit, 0);
    bus.ccwait = 1'b0; bus.ccinv = 1'b0;
    stall = 1'b0;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      #1;
      if (bus.dhit) begin
        ok = 1'b1;
        rd = bus.dmemload;
      end else begin
        @(negedge CLK);
        n++;
      end
    end
    bus.dmemREN = 1'b0;
    chk("dv_ok", ok, 1);
    chk("dv_data", rd, pat(32'h200));
    chk("dv_nlog", log_q.size(), 2);
    chk("dv_e0a", ev(0).a, 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
